// File: rtl/core_pkg.sv
// Shared definitions for the core stage sequencer and the pipeline stages.
// Holds the state encodings, the PC step, the exec-latch bundle and the fault check.
package core_pkg;

    localparam logic [2:0] STATE_FETCH  = 3'd0;
    localparam logic [2:0] STATE_DECODE = 3'd1;
    localparam logic [2:0] STATE_EXEC   = 3'd2;
    localparam logic [2:0] STATE_MEM    = 3'd3;
    localparam logic [2:0] STATE_WB     = 3'd4;
    localparam logic [2:0] STATE_HALT   = 3'd5;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [2:0] {
        S_FETCH  = STATE_FETCH,
        S_DECODE = STATE_DECODE,
        S_EXEC   = STATE_EXEC,
        S_MEM    = STATE_MEM,
        S_WB     = STATE_WB,
        S_HALT   = STATE_HALT
    } state_t;

    typedef struct packed {
        logic        branch;
        logic [31:0] branch_addr;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
    } exec_lat_t;

    // A load and store at once, or a branch to an unaligned target,
    // cannot be executed and stops the core.
    function automatic logic exec_fault(
        input logic       br,
        input logic [1:0] addr_lo,
        input logic       rd,
        input logic       wr
    );
        return (rd & wr) | (br & (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/core_seq_if.sv
// Memory handshake bundle between the sequencer and instruction/data memory.
// master = sequencer side (drives requests); slave = memory side.
interface core_seq_if;

    logic        imem_req;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        output imem_req,
        input  imem_valid,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        output imem_valid,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        output dmem_ready
    );

endinterface

// File: rtl/perf_counters.sv
// Cycle and retired-instruction counters, both wrapping at 2^32.
// Ports: clk, rst (sync high), count_en (cycle tick), retire (instr tick),
//        cycle_cnt, instret.
module perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_en,
    input  logic        retire,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            if (count_en) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (retire) begin
                instret <= instret + 32'd1;
            end
        end
    end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle stage sequencer: owns pc, state code, exec latches and commit.
// Ports: clk, rst (sync high), mem_bus (imem/dmem handshake, master),
//        halt_in (DECODE), branch/branch_addr/mem_*_in/reg_write_in (EXEC),
//        state, pc, instr, reg_we, halted, err, cycle_cnt, instret.
module core_seq
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    core_seq_if.master  mem_bus,
    input  logic        halt_in,
    input  logic        branch,
    input  logic [31:0] branch_addr,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        reg_write_in,
    output logic [2:0]  state,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        reg_we,
    output logic        halted,
    output logic        err,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    exec_lat_t   ex_q;
    logic        err_q;
    logic        fault;
    logic        mem_op;
    logic        run;

    assign fault  = exec_fault(branch, branch_addr[1:0],
                               mem_read_in, mem_write_in);
    assign mem_op = mem_read_in | mem_write_in;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_bus.imem_valid) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = halt_in ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (fault) begin
                    state_d = S_HALT;
                end else if (mem_op) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_bus.dmem_ready) begin
                    state_d = S_WB;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ex_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && mem_bus.imem_valid) begin
                instr_q <= mem_bus.imem_rdata;
            end
            if (state_q == S_EXEC) begin
                ex_q <= '{
                    branch:      branch,
                    branch_addr: branch_addr,
                    mem_read:    mem_read_in,
                    mem_write:   mem_write_in,
                    reg_write:   reg_write_in
                };
                if (fault) begin
                    err_q <= 1'b1;
                end
            end
            // pc moves only when leaving WB; the add wraps naturally.
            if (state_q == S_WB) begin
                pc_q <= ex_q.branch ? ex_q.branch_addr : pc_q + PC_INC;
            end
        end
    end

    // Strobes are forced low while rst is high so a reset that lands
    // mid-access or in WB never issues a request or a register write.
    assign run = ~rst;

    assign mem_bus.imem_req = run & (state_q == S_FETCH);
    assign mem_bus.dmem_req = run & (state_q == S_MEM)
                            & (ex_q.mem_read | ex_q.mem_write);
    assign mem_bus.dmem_we  = run & (state_q == S_MEM) & ex_q.mem_write;

    assign reg_we = run & (state_q == S_WB) & ex_q.reg_write;
    assign halted = run & (state_q == S_HALT);
    assign state  = state_q;
    assign pc     = pc_q;
    assign instr  = instr_q;
    assign err    = err_q;

    perf_counters u_perf (
        .clk       (clk),
        .rst       (rst),
        .count_en  (state_q != S_HALT),
        .retire    (state_q == S_WB),
        .cycle_cnt (cycle_cnt),
        .instret   (instret)
    );

endmodule

// File: tb/tb_core_seq.sv
// Scoreboard bench for core_seq: directed instructions push expected
// retire/halt records; a monitor pops and compares on each event.
module tb_core_seq;
    import core_pkg::*;

    localparam logic [31:0] RPC = 32'd152;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_in;
    logic        branch;
    logic [31:0] branch_addr;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        reg_write_in;
    logic [2:0]  state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        reg_we;
    logic        halted;
    logic        err;
    logic [31:0] cycle_cnt;
    logic [31:0] instret;

    core_seq_if bus ();

    core_seq #(.RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_bus      (bus),
        .halt_in      (halt_in),
        .branch       (branch),
        .branch_addr  (branch_addr),
        .mem_read_in  (mem_read_in),
        .mem_write_in (mem_write_in),
        .reg_write_in (reg_write_in),
        .state        (state),
        .pc           (pc),
        .instr        (instr),
        .reg_we       (reg_we),
        .halted       (halted),
        .err          (err),
        .cycle_cnt    (cycle_cnt),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        bit          is_halt;
        bit          exp_err;
        logic [31:0] pc;
        logic [31:0] instret;
        logic [31:0] cc;
        logic [31:0] word;
        int          lat;
        int          mem;
        int          wr;
        int          we;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    bit    done_req = 1'b0;
    bit    mon_done = 1'b0;

    logic [31:0] pc_m;
    logic [31:0] instret_m;
    logic [31:0] cc_m;
    int          seq_n = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin : monitor
        state_t s;
        state_t prev;
        item_t  cur;
        item_t  hit;
        int     lat;
        int     mc;
        int     wc;
        int     wec;
        prev = S_FETCH;
        lat  = 0;
        mc   = 0;
        wc   = 0;
        wec  = 0;
        while (!mon_done) begin
            @(posedge clk);
            #1;
            if (done_req) begin
                chk("queue_drained", sb.size(), 0);
                mon_done = 1'b1;
            end else if (rst) begin
                chk("rst_state", {29'd0, state}, 0);
                chk("rst_pc", pc, RPC);
                chk("rst_instr", instr, 0);
                chk("rst_err", {31'd0, err}, 0);
                chk("rst_cycle_cnt", cycle_cnt, 0);
                chk("rst_instret", instret, 0);
                chk("rst_outs_low", {28'd0, bus.imem_req, bus.dmem_req,
                                     reg_we, halted}, 0);
                chk("no_partial_wb", wc, 0);
                prev = S_FETCH;
                lat  = 1;
                mc   = 0;
                wc   = 0;
                wec  = 0;
            end else begin
                s = state_t'(state);
                if (prev == S_WB && s == S_FETCH) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_retire", 1, 0);
                    end else begin
                        cur = sb.pop_front();
                        chk({cur.nm, "_kind"}, {31'd0, cur.is_halt}, 0);
                        chk({cur.nm, "_pc"}, pc, cur.pc);
                        chk({cur.nm, "_instret"}, instret, cur.instret);
                        chk({cur.nm, "_cycle_cnt"}, cycle_cnt, cur.cc);
                        chk({cur.nm, "_instr"}, instr, cur.word);
                        chk({cur.nm, "_latency"}, lat, cur.lat);
                        chk({cur.nm, "_dmem_req_cycles"}, mc, cur.mem);
                        chk({cur.nm, "_dmem_we_cycles"}, wec, cur.wr);
                        chk({cur.nm, "_reg_we_cycles"}, wc, cur.we);
                    end
                    lat = 0;
                    mc  = 0;
                    wc  = 0;
                    wec = 0;
                end
                if (s == S_HALT) begin
                    if (prev != S_HALT) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_halt", 1, 0);
                        end else begin
                            cur = sb.pop_front();
                            hit = cur;
                            chk({cur.nm, "_kind"}, {31'd0, cur.is_halt}, 1);
                            chk({cur.nm, "_err"}, {31'd0, err},
                                {31'd0, cur.exp_err});
                            chk({cur.nm, "_pc"}, pc, cur.pc);
                            chk({cur.nm, "_cycle_cnt"}, cycle_cnt, cur.cc);
                            chk({cur.nm, "_instret"}, instret, cur.instret);
                            chk({cur.nm, "_latency"}, lat, cur.lat);
                            chk({cur.nm, "_halt_outs"},
                                {28'd0, halted, bus.imem_req,
                                 bus.dmem_req, reg_we}, 32'h8);
                        end
                    end else begin
                        chk({hit.nm, "_frozen_cnt"}, cycle_cnt, hit.cc);
                        chk({hit.nm, "_frozen_pc"}, pc, hit.pc);
                    end
                end else begin
                    lat++;
                    if (bus.dmem_req === 1'b1) mc++;
                    if (bus.dmem_we === 1'b1) wec++;
                    if (reg_we === 1'b1) wc++;
                end
                prev = s;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        pc_m      = RPC;
        instret_m = '0;
        cc_m      = '0;
    endtask

    // Runs one instruction starting at a negedge in FETCH. abort_mem >= 0
    // asserts rst during that MEM cycle (0 = first) instead of completing.
    task automatic run_instr(input string nm, input int iw, input int dw,
                             input bit h, input bit br,
                             input logic [31:0] ba, input bit mr,
                             input bit mw, input bit rw,
                             input int abort_mem);
        item_t it;
        bit    flt;
        bit    left;
        bit    fin;
        int    fc;
        int    mc;
        seq_n++;
        flt        = !h && ((mr && mw) || (br && ba[1:0] != 2'b00));
        it.nm      = nm;
        it.word    = 32'hA000_0000 + 32'(seq_n);
        it.is_halt = h || flt;
        it.exp_err = flt;
        it.mem     = 0;
        it.wr      = 0;
        it.we      = 0;
        if (it.is_halt) begin
            it.lat = iw + (h ? 2 : 3);
            cc_m   = cc_m + 32'(it.lat);
        end else begin
            it.lat = iw + 4 + ((mr || mw) ? dw + 1 : 0);
            it.mem = (mr || mw) ? dw + 1 : 0;
            it.wr  = mw ? dw + 1 : 0;
            it.we  = rw ? 1 : 0;
            cc_m      = cc_m + 32'(it.lat);
            instret_m = instret_m + 32'd1;
            pc_m      = br ? ba : pc_m + 32'd4;
        end
        it.pc      = pc_m;
        it.instret = instret_m;
        it.cc      = cc_m;
        if (abort_mem < 0) sb.push_back(it);

        halt_in        = h;
        branch         = br;
        branch_addr    = ba;
        mem_read_in    = mr;
        mem_write_in   = mw;
        reg_write_in   = rw;
        bus.imem_rdata = it.word;
        fc   = 0;
        mc   = 0;
        left = 1'b0;
        fin  = 1'b0;
        for (int c = 0; c < 300 && !fin; c++) begin
            if (state == STATE_FETCH) begin
                if (left) begin
                    fin = 1'b1;
                end else begin
                    bus.imem_valid = (fc >= iw);
                    fc++;
                end
            end else begin
                bus.imem_valid = 1'b0;
                left = 1'b1;
            end
            if (!fin && state == STATE_MEM) begin
                if (abort_mem >= 0 && mc == abort_mem) begin
                    bus.dmem_ready = 1'b0;
                    do_reset();
                    return;
                end
                bus.dmem_ready = (mc >= dw);
                mc++;
            end else begin
                bus.dmem_ready = 1'b0;
            end
            if (state == STATE_HALT) fin = 1'b1;
            if (!fin) @(negedge clk);
        end
        if (!fin) begin
            $display("FAIL %s_timeout: got no completion expected one", nm);
            $fatal(1);
        end
    endtask

    initial begin : stim
        halt_in        = 1'b0;
        branch         = 1'b0;
        branch_addr    = '0;
        mem_read_in    = 1'b0;
        mem_write_in   = 1'b0;
        reg_write_in   = 1'b0;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_ready = 1'b0;
        do_reset();

        // name, iw, dw, halt, br, addr, rd, wr, rw, abort
        run_instr("alu", 0, 0, 0, 0, 32'd0, 0, 0, 1, -1);
        run_instr("br_taken", 0, 0, 0, 1, 32'd148, 0, 0, 0, -1);
        do_reset();
        run_instr("load_wait3", 0, 3, 0, 0, 32'd0, 1, 0, 1, -1);
        run_instr("store_iwait2", 2, 0, 0, 0, 32'd0, 0, 1, 0, -1);
        run_instr("br_top", 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1, -1);
        run_instr("pc_wrap", 0, 0, 0, 0, 32'd0, 0, 0, 1, -1);
        run_instr("halt_dec", 1, 0, 1, 0, 32'd0, 0, 0, 1, -1);
        repeat (3) @(negedge clk);
        do_reset();
        run_instr("fault_br", 0, 0, 0, 1, 32'd150, 0, 0, 1, -1);
        repeat (4) @(negedge clk);
        do_reset();
        run_instr("fault_ldst", 0, 0, 0, 0, 32'd0, 1, 1, 0, -1);
        repeat (2) @(negedge clk);
        do_reset();
        run_instr("abort", 0, 5, 0, 0, 32'd0, 1, 0, 1, 1);
        run_instr("post_abort", 0, 0, 0, 0, 32'd0, 0, 0, 0, -1);

        done_req = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
